// File: rtl/pmem_line_responder.sv
// pmem_line_responder: fixed-latency responder for the LC-3b cache's
// line-granularity physical-memory port. Stores DEPTH 128-bit lines and
// answers every read or write with a one-cycle pmem_resp exactly LATENCY
// cycles after the request is accepted.
module pmem_line_responder #(
    parameter int DEPTH   = 256,  // lines stored; power of two, at most 4096
    parameter int LATENCY = 4     // acceptance-to-resp cycles, 1..15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    input  logic         pmem_read,
    input  logic         pmem_write,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         pmem_error
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [3:0]   r_cnt;

    // Request captured at acceptance; the initiator may change its inputs later.
    logic [11:0]  r_idx;
    logic         r_is_write;
    logic [127:0] r_wdata;

    logic [127:0] r_rdata;
    logic         r_error;
    logic [127:0] r_mem [DEPTH];

    logic         w_req;
    logic         w_accept;
    logic         w_access;
    logic         w_acc_write;
    logic [11:0]  w_acc_idx;
    logic [127:0] w_acc_wdata;
    logic         w_acc_in_range;
    logic [IDX_W-1:0] w_mem_addr;
    logic         w_mem_we;
    logic         w_unused_addr_bits;

    assign w_req = pmem_read | pmem_write;

    // The byte offset inside a line carries no meaning for line accesses.
    assign w_unused_addr_bits = ^pmem_address[3:0];

    // With LATENCY=1 the array access coincides with acceptance, so the
    // access operands come straight from the ports while still in IDLE.
    assign w_acc_write    = (r_state == ST_IDLE) ? pmem_write          : r_is_write;
    assign w_acc_idx      = (r_state == ST_IDLE) ? pmem_address[15:4]  : r_idx;
    assign w_acc_wdata    = (r_state == ST_IDLE) ? pmem_wdata          : r_wdata;
    assign w_acc_in_range = ({1'b0, w_acc_idx} < 13'(DEPTH));
    assign w_mem_addr     = w_acc_idx[IDX_W-1:0];

    // A reset arriving with an access pending must not commit the write.
    assign w_mem_we = w_access & w_acc_write & w_acc_in_range & ~reset;

    // Next-state decode, acceptance/access strobes and the resp pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        pmem_resp    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_access     = 1'b1;
                        w_state_next = ST_RESP;
                    end else begin
                        w_state_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // The final decrement (1 -> 0) is the access edge.
                if (r_cnt <= 4'd1) begin
                    w_access     = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                pmem_resp    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latency counter: loads at acceptance, counts down while BUSY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= CNT_LOAD;
        end else if (r_state == ST_BUSY && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Capture the request operands at acceptance; a request with both ops
    // high executes as a write.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx      <= pmem_address[15:4];
            r_is_write <= pmem_write;
            r_wdata    <= pmem_wdata;
        end
    end

    // Read data register: updated only when a read completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_access && !w_acc_write) begin
            r_rdata <= w_acc_in_range ? r_mem[w_mem_addr] : '0;
        end
    end

    // Sticky error: simultaneous read+write, or a line beyond DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if ((w_accept && pmem_read && pmem_write) ||
                     (w_access && !w_acc_in_range)) begin
            r_error <= 1'b1;
        end
    end

    // Line array write port.
    always_ff @(posedge clk) begin
        // NOTE: the line array has no reset so it maps onto block RAM; its contents are undefined until written.
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_acc_wdata;
        end
    end

    assign pmem_rdata = r_rdata;
    assign pmem_error = r_error;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder: three instances cover the
// default configuration, a 16-line array and a one-cycle latency.
module tb_pmem_line_responder;

    localparam logic [127:0] LINE1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] LINE2 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] LINE3 = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
    localparam logic [127:0] LINE4 = 128'h1357_9BDF_2468_ACE0_1111_2222_3333_4444;
    localparam logic [127:0] LINE5 = 128'hCAFE_F00D_0BAD_BEEF_8000_0000_0000_0001;
    localparam logic [127:0] PRIOR = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    localparam logic [127:0] OLD   = 128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF;
    localparam logic [127:0] NEW   = 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0000;

    logic clk = 1'b0;
    logic reset;

    logic [15:0]  a_addr, b_addr, c_addr;
    logic [127:0] a_wdata, b_wdata, c_wdata;
    logic         a_read, b_read, c_read;
    logic         a_write, b_write, c_write;
    logic [127:0] a_rdata, b_rdata, c_rdata;
    logic         a_resp, b_resp, c_resp;
    logic         a_error, b_error, c_error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pmem_line_responder #(.DEPTH(256), .LATENCY(4)) u_dut (
        .clk(clk), .reset(reset),
        .pmem_address(a_addr), .pmem_wdata(a_wdata),
        .pmem_read(a_read), .pmem_write(a_write),
        .pmem_rdata(a_rdata), .pmem_resp(a_resp), .pmem_error(a_error)
    );

    pmem_line_responder #(.DEPTH(16), .LATENCY(4)) u_d16 (
        .clk(clk), .reset(reset),
        .pmem_address(b_addr), .pmem_wdata(b_wdata),
        .pmem_read(b_read), .pmem_write(b_write),
        .pmem_rdata(b_rdata), .pmem_resp(b_resp), .pmem_error(b_error)
    );

    pmem_line_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .pmem_address(c_addr), .pmem_wdata(c_wdata),
        .pmem_read(c_read), .pmem_write(c_write),
        .pmem_rdata(c_rdata), .pmem_resp(c_resp), .pmem_error(c_error)
    );

    function automatic logic get_resp(input int sel);
        case (sel)
            0:       return a_resp;
            1:       return b_resp;
            default: return c_resp;
        endcase
    endfunction

    function automatic logic [127:0] get_rdata(input int sel);
        case (sel)
            0:       return a_rdata;
            1:       return b_rdata;
            default: return c_rdata;
        endcase
    endfunction

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [127:0] wd);
        case (sel)
            0: begin a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd; end
            1: begin b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd; end
            default: begin c_read = rd; c_write = wr; c_addr = addr; c_wdata = wd; end
        endcase
    endtask

    // One transaction: n = edges from acceptance (inclusive) to resp seen,
    // 0 on timeout; rdat sampled in the resp cycle; resp_after one cycle later.
    task automatic run_txn(input int sel, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [127:0] wd,
                           output int n, output logic [127:0] rdat,
                           output logic resp_after);
        drive(sel, rd, wr, addr, wd);
        @(posedge clk); #1;
        n = 1;
        while (!get_resp(sel) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        rdat = get_rdata(sel);
        if (get_resp(sel) !== 1'b1) n = 0;
        drive(sel, 1'b0, 1'b0, addr, wd);
        @(posedge clk); #1;
        resp_after = get_resp(sel);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, '0);
        drive(1, 1'b0, 1'b0, 16'h0, '0);
        drive(2, 1'b0, 1'b0, 16'h0, '0);
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_resp !== 1'b0) begin bad++; $display("FAIL reset_resp: got %b want 0", a_resp); end
        total++; if (a_rdata !== 128'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", a_rdata); end
        total++; if (a_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", a_error); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_latency();
        int n; logic [127:0] rd; logic ra;
        run_txn(0, 1'b0, 1'b1, 16'h0040, LINE1, n, rd, ra);
        total++; if (n !== 4) begin bad++; $display("FAIL write_latency: got %0d want 4", n); end
        total++; if (ra !== 1'b0) begin bad++; $display("FAIL write_resp_width: resp after pulse %b want 0", ra); end
        total++; if (a_error !== 1'b0) begin bad++; $display("FAIL write_error: got %b want 0", a_error); end
    endtask

    task automatic test_read_back();
        int n; logic [127:0] rd; logic ra;
        run_txn(0, 1'b1, 1'b0, 16'h004C, '0, n, rd, ra);
        total++; if (n !== 4) begin bad++; $display("FAIL read_latency: got %0d want 4", n); end
        total++; if (rd !== LINE1) begin bad++; $display("FAIL read_data: got %h want %h", rd, LINE1); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_rdata !== LINE1) begin bad++; $display("FAIL rdata_hold_idle: got %h want %h", a_rdata, LINE1); end
        run_txn(0, 1'b0, 1'b1, 16'h0300, LINE2, n, rd, ra);
        total++; if (a_rdata !== LINE1) begin bad++; $display("FAIL rdata_hold_write: got %h want %h", a_rdata, LINE1); end
    endtask

    task automatic test_back_to_back();
        int p1; int p2;
        p1 = 0; p2 = 0;
        drive(0, 1'b1, 1'b0, 16'h0040, '0);
        for (int e = 1; e <= 30 && p2 == 0; e++) begin
            @(posedge clk); #1;
            if (a_resp === 1'b1) begin
                if (p1 == 0) p1 = e;
                else p2 = e;
            end
        end
        drive(0, 1'b0, 1'b0, 16'h0040, '0);
        @(posedge clk); #1;
        total++; if (p1 !== 4) begin bad++; $display("FAIL b2b_first: got %0d want 4", p1); end
        total++; if (p2 - p1 !== 5) begin bad++; $display("FAIL b2b_spacing: got %0d want 5", p2 - p1); end
        total++; if (a_rdata !== LINE1) begin bad++; $display("FAIL b2b_data: got %h want %h", a_rdata, LINE1); end
    endtask

    task automatic test_addr_change();
        int n; logic [127:0] rd; logic ra;
        run_txn(0, 1'b0, 1'b1, 16'h0080, PRIOR, n, rd, ra);
        drive(0, 1'b0, 1'b1, 16'h0040, LINE3);
        @(posedge clk); #1;
        // Mid-BUSY: new address, new data, and even the op flipped to read.
        drive(0, 1'b1, 1'b0, 16'h0080, LINE4);
        n = 1;
        while (a_resp !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (n !== 4) begin bad++; $display("FAIL change_latency: got %0d want 4", n); end
        drive(0, 1'b0, 1'b0, 16'h0, '0);
        @(posedge clk); #1;
        run_txn(0, 1'b1, 1'b0, 16'h0040, '0, n, rd, ra);
        total++; if (rd !== LINE3) begin bad++; $display("FAIL change_target_line: got %h want %h", rd, LINE3); end
        run_txn(0, 1'b1, 1'b0, 16'h0080, '0, n, rd, ra);
        total++; if (rd !== PRIOR) begin bad++; $display("FAIL change_other_line: got %h want %h", rd, PRIOR); end
    endtask

    task automatic test_both_ops();
        int n; logic [127:0] rd; logic ra;
        total++; if (a_error !== 1'b0) begin bad++; $display("FAIL both_error_before: got %b want 0", a_error); end
        run_txn(0, 1'b1, 1'b1, 16'h0500, LINE5, n, rd, ra);
        total++; if (n !== 4) begin bad++; $display("FAIL both_latency: got %0d want 4", n); end
        total++; if (a_error !== 1'b1) begin bad++; $display("FAIL both_error_set: got %b want 1", a_error); end
        run_txn(0, 1'b1, 1'b0, 16'h0500, '0, n, rd, ra);
        total++; if (rd !== LINE5) begin bad++; $display("FAIL both_as_write: got %h want %h", rd, LINE5); end
        total++; if (a_error !== 1'b1) begin bad++; $display("FAIL both_error_sticky: got %b want 1", a_error); end
    endtask

    task automatic test_reset_abort();
        int n; logic [127:0] rd; logic ra; logic saw;
        run_txn(0, 1'b0, 1'b1, 16'h0200, OLD, n, rd, ra);
        drive(0, 1'b0, 1'b1, 16'h0200, NEW);
        @(posedge clk); #1;   // accepted
        @(posedge clk); #1;   // in BUSY
        drive(0, 1'b0, 1'b0, 16'h0200, NEW);
        reset = 1'b1;
        #1;
        total++; if (a_resp !== 1'b0) begin bad++; $display("FAIL abort_resp: got %b want 0", a_resp); end
        total++; if (a_rdata !== 128'h0) begin bad++; $display("FAIL abort_rdata: got %h want 0", a_rdata); end
        total++; if (a_error !== 1'b0) begin bad++; $display("FAIL abort_error: got %b want 0", a_error); end
        saw = 1'b0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            if (e == 1) reset = 1'b0;
            if (a_resp !== 1'b0) saw = 1'b1;
        end
        total++; if (saw !== 1'b0) begin bad++; $display("FAIL abort_no_resp: saw resp %b want 0", saw); end
        run_txn(0, 1'b1, 1'b0, 16'h0200, '0, n, rd, ra);
        total++; if (n !== 4) begin bad++; $display("FAIL abort_read_latency: got %0d want 4", n); end
        total++; if (rd !== OLD) begin bad++; $display("FAIL abort_old_data: got %h want %h", rd, OLD); end
    endtask

    task automatic test_depth16();
        int n; logic [127:0] rd; logic ra;
        run_txn(1, 1'b0, 1'b1, 16'h0000, LINE3, n, rd, ra);
        run_txn(1, 1'b0, 1'b1, 16'h00F0, LINE1, n, rd, ra);
        run_txn(1, 1'b1, 1'b0, 16'h00F0, '0, n, rd, ra);
        total++; if (rd !== LINE1) begin bad++; $display("FAIL d16_last_line: got %h want %h", rd, LINE1); end
        total++; if (b_error !== 1'b0) begin bad++; $display("FAIL d16_error_clear: got %b want 0", b_error); end
        run_txn(1, 1'b1, 1'b0, 16'h0100, '0, n, rd, ra);
        total++; if (n !== 4) begin bad++; $display("FAIL d16_oor_latency: got %0d want 4", n); end
        total++; if (rd !== 128'h0) begin bad++; $display("FAIL d16_oor_rdata: got %h want 0", rd); end
        total++; if (b_error !== 1'b1) begin bad++; $display("FAIL d16_oor_error: got %b want 1", b_error); end
        run_txn(1, 1'b0, 1'b1, 16'h0100, LINE2, n, rd, ra);
        run_txn(1, 1'b1, 1'b0, 16'h0000, '0, n, rd, ra);
        total++; if (rd !== LINE3) begin bad++; $display("FAIL d16_oor_write_dropped: got %h want %h", rd, LINE3); end
    endtask

    task automatic test_latency1();
        int n; logic [127:0] rd; logic ra;
        run_txn(2, 1'b0, 1'b1, 16'h0040, LINE4, n, rd, ra);
        total++; if (n !== 1) begin bad++; $display("FAIL lat1_write_latency: got %0d want 1", n); end
        total++; if (ra !== 1'b0) begin bad++; $display("FAIL lat1_resp_width: got %b want 0", ra); end
        run_txn(2, 1'b1, 1'b0, 16'h0048, '0, n, rd, ra);
        total++; if (n !== 1) begin bad++; $display("FAIL lat1_read_latency: got %0d want 1", n); end
        total++; if (rd !== LINE4) begin bad++; $display("FAIL lat1_read_data: got %h want %h", rd, LINE4); end
        total++; if (c_error !== 1'b0) begin bad++; $display("FAIL lat1_error: got %b want 0", c_error); end
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_read_back();
        test_back_to_back();
        test_addr_change();
        test_both_ops();
        test_reset_abort();
        test_depth16();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
- Synthesizable responder for the line-granularity physical-memory interface that our LC-3b cache drives as initiator.
- Accepts 128-bit line reads and writes, waits a fixed programmable latency, then returns a one-cycle pmem_resp.
- Backs the lines with an internal line array.
- Replaces the behavioural memory model for FPGA bring-up; gives the cache bench a cycle-exact, repeatable memory.

Parameters:
- DEPTH, 256: number of 128-bit lines stored; line index = pmem_address[15:4]; must be a power of two, max 4096.
- LATENCY, 4: cycles from request acceptance to pmem_resp; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- pmem_address  in  16  byte address (lc3b_word); bits [3:0] ignored.
- pmem_wdata  in  128  write line (lc3b_data).
- pmem_read  in  1  read request, held high by initiator until pmem_resp.
- pmem_write  in  1  write request, held high by initiator until pmem_resp.
- pmem_rdata  out  128  read line (lc3b_data); valid in the pmem_resp cycle.
- pmem_resp  out  1  one-cycle completion pulse.
- pmem_error  out  1  sticky protocol/range error flag.

Behaviour:
- Reset (async assert, sync-to-clk effect on release):
  - FSM goes to IDLE; pmem_resp=0, pmem_rdata=0, pmem_error=0, latency counter=0.
  - Line array is NOT cleared; contents before first write are undefined.
  - Reset mid-operation aborts the transaction: no resp is issued and a pending write is not committed.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Request seen high (read or write) at edge k: latch line index, op and pmem_wdata; counter loads LATENCY-1; go to BUSY, or straight to RESP if LATENCY=1.
  - pmem_resp rises in the cycle after edge k+LATENCY-1, i.e. exactly LATENCY cycles after acceptance.
- BUSY: counter decrements each edge; at 0 go to RESP.
- Array access happens on the BUSY->RESP edge (or the IDLE->RESP edge when LATENCY=1):
  - Write: array[idx] <= latched wdata.
  - Read: pmem_rdata <= array[idx].
- RESP:
  - pmem_resp=1 for exactly one cycle, then IDLE.
  - pmem_rdata holds its value until the next read completes; writes do not change it.
- Back-to-back: a request still high in the cycle after RESP is a new transaction. Initiators must drop the request in that cycle unless they want another access.
- Inputs latched at acceptance: changes to address, wdata or op during BUSY are ignored.
- Both pmem_read and pmem_write high at acceptance: treated as a write; pmem_error set.
- Request dropped during BUSY: the transaction still completes and resp is still pulsed; no error.
- Out-of-range line (idx >= DEPTH, only possible when DEPTH < 4096):
  - Read returns all-zero data; write is discarded.
  - pmem_error is set; resp timing is unchanged.
- pmem_error stays set until reset.
- Read after write to the same line returns the new data; no forwarding is needed because accesses are serialized.

Test Plan:
- Reset, then write 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to 0x0040 with LATENCY=4 -> pmem_resp high exactly 4 cycles after acceptance, for 1 cycle; pmem_error=0.
- Read 0x004C (same line, low bits ignored) -> resp after 4 cycles; pmem_rdata equals the written line; pmem_rdata stable after resp until the next read.
- Hold pmem_read continuously across two completions -> two transactions, with resp pulses separated by LATENCY+1 cycles.
- Change pmem_address from 0x0040 to 0x0080 and wdata mid-BUSY on a write -> only line 0x0040 is updated; line 0x0080 keeps its prior value.
- Assert pmem_read and pmem_write together -> executes as a write, pmem_error=1 and stays 1.
- With DEPTH=16, read 0x0100 -> rdata=0, error=1.
- Assert reset during BUSY of a write to 0x0200 -> no resp, outputs reset to 0, and a later read of 0x0200 returns the old data.
- With LATENCY=1 -> resp in the cycle immediately after acceptance.
